// File: rtl/systolic_ctrl_if.sv
// Launcher, operand-buffer and PE-array edge signals of the systolic array job sequencer.
// master = controller side, slave = launcher/memories/array side.
interface systolic_ctrl_if #(
    parameter int DATA_BIT = 8,
    parameter int N        = 4,
    parameter int K_MAX    = 16,
    parameter int AW       = 4
) ();
    localparam int KW = $clog2(K_MAX + 1);

    logic                  start;
    logic [KW-1:0]         k_len;
    logic                  abort;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic                  a_rd_en;
    logic [AW-1:0]         a_rd_addr;
    logic [N*DATA_BIT-1:0] a_rd_data;
    logic                  b_rd_en;
    logic [AW-1:0]         b_rd_addr;
    logic [N*DATA_BIT-1:0] b_rd_data;
    logic [N*DATA_BIT-1:0] array_west;
    logic [N*DATA_BIT-1:0] array_north;
    logic                  array_clr;

    modport master (
        input  start, k_len, abort, a_rd_data, b_rd_data,
        output busy, done, err, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
               array_west, array_north, array_clr
    );

    modport slave (
        output start, k_len, abort, a_rd_data, b_rd_data,
        input  busy, done, err, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
               array_west, array_north, array_clr
    );
endinterface

// File: rtl/systolic_ctrl.sv
// Job sequencer for an N x N output-stationary systolic array: clear, feed skewed operands, flush, done.
// Optional SYSTOLIC_CTRL_PERF_EN adds busy-cycle and completed-job counters.
module systolic_ctrl #(
    parameter int DATA_BIT = 8,
    parameter int N        = 4,
    parameter int K_MAX    = 16,
    parameter int AW       = 4
) (
    input  logic            clk,
    input  logic            rst,
    systolic_ctrl_if.master bus
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    output logic [31:0]     perf_busy_cycles,
    output logic [15:0]     perf_jobs
`endif
);
    localparam int KW        = $clog2(K_MAX + 1);
    localparam int FLUSH_LEN = 2 * N + 3;
    localparam int CW        = $clog2(FLUSH_LEN + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DONE} state_t;

    state_t              state_q, state_d;
    logic [KW-1:0]       klen_q, klen_d;
    logic [AW:0]         k_q, k_d;
    logic [CW-1:0]       fl_q, fl_d;
    logic                clr_q, clr_d;
    logic                err_q, err_d;
    logic                vld_q, vld_d;
    logic                rd_en;
    logic                abort_hit;
    logic [DATA_BIT-1:0] w_q [N][N];
    logic [DATA_BIT-1:0] w_d [N][N];
    logic [DATA_BIT-1:0] n_q [N][N];
    logic [DATA_BIT-1:0] n_d [N][N];

    always_comb begin
        state_d   = state_q;
        klen_d    = klen_q;
        k_d       = k_q;
        fl_d      = fl_q;
        clr_d     = 1'b0;
        err_d     = 1'b0;
        rd_en     = 1'b0;
        abort_hit = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.k_len != '0 && 32'(bus.k_len) <= K_MAX) begin
                        state_d = CLEAR;
                        klen_d  = bus.k_len;
                        k_d     = '0;
                        clr_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            CLEAR: begin
                state_d = FEED;
                fl_d    = '0;
            end
            FEED: begin
                rd_en = 1'b1;
                // Address holds at k_len-1 once the last word is requested.
                if (32'(k_q) + 32'd1 == 32'(klen_q)) begin
                    state_d = FLUSH;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            FLUSH: begin
                if (fl_q == CW'(FLUSH_LEN - 1)) begin
                    state_d = DONE;
                end else begin
                    fl_d = fl_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.abort && (state_q == CLEAR || state_q == FEED || state_q == FLUSH)) begin
            abort_hit = 1'b1;
            state_d   = IDLE;
            clr_d     = 1'b1;
            rd_en     = 1'b0;
        end
    end

    // Lane i uses stages 0..i; unused stages stay zero. Abort wipes in-flight operands.
    always_comb begin
        vld_d = rd_en;
        for (int i = 0; i < N; i++) begin
            w_d[i][0] = '0;
            n_d[i][0] = '0;
            if (!abort_hit && vld_q) begin
                w_d[i][0] = bus.a_rd_data[i*DATA_BIT +: DATA_BIT];
                n_d[i][0] = bus.b_rd_data[i*DATA_BIT +: DATA_BIT];
            end
            for (int s = 1; s < N; s++) begin
                w_d[i][s] = '0;
                n_d[i][s] = '0;
                if (!abort_hit && s <= i) begin
                    w_d[i][s] = w_q[i][s-1];
                    n_d[i][s] = n_q[i][s-1];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            klen_q  <= '0;
            k_q     <= '0;
            fl_q    <= '0;
            clr_q   <= 1'b0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                for (int s = 0; s < N; s++) begin
                    w_q[i][s] <= '0;
                    n_q[i][s] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            klen_q  <= klen_d;
            k_q     <= k_d;
            fl_q    <= fl_d;
            clr_q   <= clr_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            for (int i = 0; i < N; i++) begin
                for (int s = 0; s < N; s++) begin
                    w_q[i][s] <= w_d[i][s];
                    n_q[i][s] <= n_d[i][s];
                end
            end
        end
    end

    always_comb begin
        bus.array_west  = '0;
        bus.array_north = '0;
        for (int i = 0; i < N; i++) begin
            bus.array_west[i*DATA_BIT +: DATA_BIT]  = w_q[i][i];
            bus.array_north[i*DATA_BIT +: DATA_BIT] = n_q[i][i];
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.err       = err_q;
    assign bus.a_rd_en   = rd_en;
    assign bus.b_rd_en   = rd_en;
    assign bus.a_rd_addr = k_q[AW-1:0];
    assign bus.b_rd_addr = k_q[AW-1:0];
    assign bus.array_clr = rst | clr_q;

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] pbusy_q, pbusy_d;
    logic [15:0] pjobs_q, pjobs_d;

    always_comb begin
        pbusy_d = pbusy_q;
        pjobs_d = pjobs_q;
        if (bus.busy && pbusy_q != '1) pbusy_d = pbusy_q + 1'b1;
        if (bus.done)                  pjobs_d = pjobs_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pbusy_q <= '0;
            pjobs_q <= '0;
        end else begin
            pbusy_q <= pbusy_d;
            pjobs_q <= pjobs_d;
        end
    end

    assign perf_busy_cycles = pbusy_q;
    assign perf_jobs        = pjobs_q;
`endif
endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: operand memories and an output-stationary MAC array model,
// with expected job results queued at launch and compared when done pulses.
`timescale 1ns/1ps
module tb_systolic_ctrl;
    localparam int DB = 8, N = 4, K_MAX = 16, AW = 4;
    localparam int KW = $clog2(K_MAX + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    systolic_ctrl_if #(.DATA_BIT(DB), .N(N), .K_MAX(K_MAX), .AW(AW)) bus ();

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] pbc;
    logic [15:0] pj;
`endif

    systolic_ctrl #(.DATA_BIT(DB), .N(N), .K_MAX(K_MAX), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
`ifdef SYSTOLIC_CTRL_PERF_EN
        ,
        .perf_busy_cycles (pbc),
        .perf_jobs        (pj)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Operand memories; junk on idle cycles checks the valid gating.
    logic [7:0] amat [N][16];
    logic [7:0] bmat [16][N];
    always @(posedge clk) begin
        logic [N*DB-1:0] aw, bw;
        for (int i = 0; i < N; i++) begin
            aw[i*DB +: DB] = bus.a_rd_en ? amat[i][bus.a_rd_addr] : 8'($urandom);
            bw[i*DB +: DB] = bus.b_rd_en ? bmat[bus.b_rd_addr][i] : 8'($urandom);
        end
        bus.a_rd_data <= aw;
        bus.b_rd_data <= bw;
    end

    // PE array model: west flows east, north flows south, 16-bit accumulate.
    logic [7:0]  pw  [N][N];
    logic [7:0]  pn  [N][N];
    logic [15:0] acc [N][N];
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                automatic logic [7:0] wi = (j == 0) ? bus.array_west[i*DB +: DB] : pw[i][j-1];
                automatic logic [7:0] ni = (i == 0) ? bus.array_north[j*DB +: DB] : pn[i-1][j];
                if (bus.array_clr) begin
                    pw[i][j]  <= '0;
                    pn[i][j]  <= '0;
                    acc[i][j] <= '0;
                end else begin
                    pw[i][j]  <= wi;
                    pn[i][j]  <= ni;
                    acc[i][j] <= acc[i][j] + 16'(wi) * 16'(ni);
                end
            end
        end
    end

    int             exp_done_q [$];
    logic [255:0]   exp_res_q  [$];
    int             addr_hits  [16];
    int             ed;
    logic [255:0]   er;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.a_rd_en) addr_hits[bus.a_rd_addr]++;
            if (bus.done) begin
                if (exp_done_q.size() == 0) begin
                    check_val("unexpected_done", 32'd1, 32'd0);
                end else begin
                    ed = exp_done_q.pop_front();
                    er = exp_res_q.pop_front();
                    check_val("done_cycle", cyc, ed);
                    for (int i = 0; i < N; i++)
                        for (int j = 0; j < N; j++)
                            check_val($sformatf("pe_%0d_%0d", i, j), 32'(acc[i][j]), 32'(er[(i*N+j)*16 +: 16]));
                end
            end
        end
    end

    function automatic logic [255:0] matmul(input int k);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                logic [15:0] s;
                s = '0;
                for (int kk = 0; kk < k; kk++) s = s + 16'(amat[i][kk]) * 16'(bmat[kk][j]);
                r[(i*N+j)*16 +: 16] = s;
            end
        return r;
    endfunction

    // mode 0: A identity, B[k][j]=10k+j+1; 1: all 255; 2: all 1; 3: random
    task automatic load(input int mode);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 16; k++) begin
                case (mode)
                    0: begin amat[i][k] = (i == k) ? 8'd1 : 8'd0; bmat[k][i] = 8'(10*k + i + 1); end
                    1: begin amat[i][k] = 8'd255; bmat[k][i] = 8'd255; end
                    2: begin amat[i][k] = 8'd1;   bmat[k][i] = 8'd1;   end
                    default: begin amat[i][k] = 8'($urandom); bmat[k][i] = 8'($urandom); end
                endcase
            end
    endtask

    // Drives start for one cycle; returns at the negedge of cycle S+1.
    task automatic launch(input int k, input bit push, output int s);
        @(negedge clk);
        bus.start = 1'b1;
        bus.k_len = KW'(k);
        s = cyc;
        if (push) begin
            exp_done_q.push_back(s + k + 2*N + 5);
            exp_res_q.push_back(matmul(k));
        end
        @(negedge clk);
        bus.start = 1'b0;
        check_val("busy_s1", 32'(bus.busy), 32'd1);
        check_val("clr_s1", 32'(bus.array_clr), 32'd1);
        check_val("west_clear", bus.array_west, 32'd0);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!bus.done && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.done) check_val("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic bad_start(input int k);
        int rd;
        @(negedge clk);
        bus.start = 1'b1;
        bus.k_len = KW'(k);
        @(negedge clk);
        bus.start = 1'b0;
        check_val($sformatf("err_k%0d", k), 32'(bus.err), 32'd1);
        check_val($sformatf("busy_k%0d", k), 32'(bus.busy), 32'd0);
        rd = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.a_rd_en || bus.b_rd_en || bus.busy) rd++;
        end
        check_val($sformatf("idle_k%0d", k), rd, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int s, nz;
        bus.start = 1'b0;
        bus.k_len = '0;
        bus.abort = 1'b0;
        load(0);
        repeat (3) @(negedge clk);
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_done", 32'(bus.done), 32'd0);
        check_val("rst_err", 32'(bus.err), 32'd0);
        check_val("rst_rd_en", 32'({bus.a_rd_en, bus.b_rd_en}), 32'd0);
        check_val("rst_addr", 32'({bus.a_rd_addr, bus.b_rd_addr}), 32'd0);
        check_val("rst_edges", bus.array_west | bus.array_north, 32'd0);
        check_val("rst_clr", 32'(bus.array_clr), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check_val("clr_released", 32'(bus.array_clr), 32'd0);

        // Identity A: PE(i,j) = B[i][j]
        launch(4, 1'b1, s);
        wait_done();
        check_val("busy_at_done", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check_val("busy_after", 32'(bus.busy), 32'd0);
`ifdef SYSTOLIC_CTRL_PERF_EN
        check_val("perf_jobs1", 32'(pj), 32'd1);
        check_val("perf_busy1", pbc, 32'd17);
`endif

        // Full depth with max operands, then back-to-back short job
        load(1);
        for (int a = 0; a < 16; a++) addr_hits[a] = 0;
        launch(16, 1'b1, s);
        wait_done();
        for (int a = 0; a < 16; a++) check_val($sformatf("addr_hit_%0d", a), addr_hits[a], 1);
        load(2);
        launch(3, 1'b1, s);
        wait_done();

        bad_start(0);
        bad_start(17);

        // Abort in FEED at k=2
        load(3);
        launch(8, 1'b0, s);
        nz = 0;
        while (!(bus.a_rd_en && bus.a_rd_addr == 4'd2) && nz < 20) begin
            @(negedge clk);
            nz++;
        end
        check_val("abort_reach_k2", 32'(bus.a_rd_addr), 32'd2);
        bus.abort = 1'b1;
        #1;
        check_val("abort_rd_drop", 32'({bus.a_rd_en, bus.b_rd_en}), 32'd0);
        @(negedge clk);
        bus.abort = 1'b0;
        check_val("abort_idle", 32'(bus.busy), 32'd0);
        check_val("abort_clr", 32'(bus.array_clr), 32'd1);
        @(negedge clk);
        check_val("abort_clr_end", 32'(bus.array_clr), 32'd0);
        nz = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.array_west != '0 || bus.array_north != '0) nz++;
        end
        check_val("abort_edges_zero", nz, 0);
        load(3);
        launch(5, 1'b1, s);
        wait_done();

        // Reset in the middle of FLUSH
        load(3);
        launch(6, 1'b1, s);
        while (cyc < s + 10) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_val("mrst_busy", 32'(bus.busy), 32'd0);
        check_val("mrst_done_err", 32'({bus.done, bus.err}), 32'd0);
        check_val("mrst_rd", 32'({bus.a_rd_en, bus.b_rd_en}), 32'd0);
        check_val("mrst_addr", 32'({bus.a_rd_addr, bus.b_rd_addr}), 32'd0);
        check_val("mrst_edges", bus.array_west | bus.array_north, 32'd0);
        check_val("mrst_clr", 32'(bus.array_clr), 32'd1);
        exp_done_q.delete();
        exp_res_q.delete();
        repeat (2) @(negedge clk);
        check_val("mrst_clr_hold", 32'(bus.array_clr), 32'd1);
        rst = 1'b0;
        #1;
        check_val("mrst_clr_rel", 32'(bus.array_clr), 32'd0);
`ifdef SYSTOLIC_CTRL_PERF_EN
        check_val("perf_busy_rst", pbc, 32'd0);
        check_val("perf_jobs_rst", 32'(pj), 32'd0);
`endif
        repeat (30) @(negedge clk);
        check_val("mrst_still_idle", 32'(bus.busy), 32'd0);
        check_val("sb_empty", exp_done_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
